// File: rtl/nco_wavegen_if.sv
// Bus bundle for nco_wavegen: control inputs and waveform outputs in one interface.
// master = the block driving frequency/phase/mode controls, slave = the oscillator.
// Ports: en, freq_in, freq_load, phase_off, mode, sync_clr -> oscillator;
//        sine_out, cosine_out, wave_out, out_valid, wrap <- oscillator.
interface nco_wavegen_if #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 10
);
  logic                    en;
  logic [ACC_W-1:0]        freq_in;
  logic                    freq_load;
  logic [ACC_W-1:0]        phase_off;
  logic [1:0]              mode;
  logic                    sync_clr;
  logic signed [OUT_W-1:0] sine_out;
  logic signed [OUT_W-1:0] cosine_out;
  logic signed [OUT_W-1:0] wave_out;
  logic                    out_valid;
  logic                    wrap;

  modport master (
    output en, freq_in, freq_load, phase_off, mode, sync_clr,
    input  sine_out, cosine_out, wave_out, out_valid, wrap
  );

  modport slave (
    input  en, freq_in, freq_load, phase_off, mode, sync_clr,
    output sine_out, cosine_out, wave_out, out_valid, wrap
  );
endinterface

// File: rtl/nco_wavegen.sv
// Purpose: phase-accumulator NCO, quarter-wave LUT, quadrature sine/cosine plus selectable wave.
// Latency: accumulator step at edge N appears on outputs after edge N+3 (valid/wrap aligned).
// Backpressure: none; the pipeline free-runs every cycle, en only gates accumulator advance.
// Ports: clock, reset (async, active-high); bus (nco_wavegen_if.slave) carries en, freq_in,
//        freq_load, phase_off, mode, sync_clr in and sine_out, cosine_out, wave_out,
//        out_valid, wrap out.
// Option: define NCO_DITHER_EN to add LFSR phase dither at the phase-offset adder.
module nco_wavegen #(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 10
) (
  input  logic         clock,
  input  logic         reset,
  nco_wavegen_if.slave bus
);

  localparam int AMP_I = 2**(OUT_W-1) - 1;
  localparam logic signed [OUT_W-1:0] AMP = OUT_W'(AMP_I);
  localparam int LUT_N = 2**LUT_AW;

  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SAW    = 2'd3;

  // Quarter-wave ROM, sampled at half-step offsets so the table never hits 0 or
  // full scale exactly and the mirrored quadrants stay symmetric.
  logic [OUT_W-2:0] lut_tbl [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_N);
    localparam int  VAL = $rtoi(real'(AMP_I) * $sin(ANG) + 0.5);
    assign lut_tbl[k] = VAL[OUT_W-2:0];
  end

  // ---------------- stage 0: accumulator ----------------
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] freq_reg;
  logic [ACC_W:0]   acc_sum;
  logic             vld0;
  logic             wrap0;

  assign acc_sum = {1'b0, acc} + {1'b0, freq_reg};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      freq_reg <= '0;
      vld0     <= 1'b0;
      wrap0    <= 1'b0;
    end else begin
      if (bus.freq_load) freq_reg <= bus.freq_in;
      if (bus.sync_clr)  acc <= '0;
      else if (bus.en)   acc <= acc_sum[ACC_W-1:0];
      vld0  <= bus.en;
      // a clear restarts the phase, so it never reports an overflow
      wrap0 <= bus.en & ~bus.sync_clr & acc_sum[ACC_W];
    end
  end

  // ---------------- stage 1: phase offset, field split ----------------
  logic [ACC_W-1:0] dither;

`ifdef NCO_DITHER_EN
  localparam int DW = ((ACC_W - LUT_AW - 2) < 16) ? (ACC_W - LUT_AW - 2) : 16;
  logic [15:0] lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign dither = ACC_W'(lfsr[DW-1:0]);
`else
  assign dither = '0;
`endif

  logic [ACC_W-1:0] p;
  assign p = acc + bus.phase_off + dither;

  // phase bits below the LUT index / wave fields only matter through the carry chain
  logic unused_p;
  assign unused_p = ^p;

  logic [1:0]        q1;
  logic [LUT_AW-1:0] i1;
  logic [OUT_W:0]    u1;
  logic [1:0]        mode1;
  logic              vld1;
  logic              wrap1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q1    <= '0;
      i1    <= '0;
      u1    <= '0;
      mode1 <= '0;
      vld1  <= 1'b0;
      wrap1 <= 1'b0;
    end else begin
      q1    <= p[ACC_W-1 -: 2];
      i1    <= p[ACC_W-3 -: LUT_AW];
      u1    <= p[ACC_W-1 -: OUT_W+1];
      mode1 <= bus.mode;
      vld1  <= vld0;
      wrap1 <= wrap0;
    end
  end

  // ---------------- stage 2: LUT read ----------------
  // odd quadrants walk the quarter table backwards; cosine is sine one quadrant ahead
  logic [1:0]        cq;
  logic [LUT_AW-1:0] sin_addr;
  logic [LUT_AW-1:0] cos_addr;

  assign cq       = q1 + 2'd1;
  assign sin_addr = q1[0] ? ~i1 : i1;
  assign cos_addr = cq[0] ? ~i1 : i1;

  logic [OUT_W-2:0] sin_m2;
  logic [OUT_W-2:0] cos_m2;
  logic             sneg2;
  logic             cneg2;
  logic [OUT_W:0]   u2;
  logic [1:0]       mode2;
  logic             vld2;
  logic             wrap2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sin_m2 <= '0;
      cos_m2 <= '0;
      sneg2  <= 1'b0;
      cneg2  <= 1'b0;
      u2     <= '0;
      mode2  <= '0;
      vld2   <= 1'b0;
      wrap2  <= 1'b0;
    end else begin
      sin_m2 <= lut_tbl[sin_addr];
      cos_m2 <= lut_tbl[cos_addr];
      sneg2  <= q1[1];
      cneg2  <= cq[1];
      u2     <= u1;
      mode2  <= mode1;
      vld2   <= vld1;
      wrap2  <= wrap1;
    end
  end

  // ---------------- stage 3: sign, wave select ----------------
  logic signed [OUT_W-1:0] sin_mag;
  logic signed [OUT_W-1:0] cos_mag;
  logic signed [OUT_W-1:0] sin_v;
  logic signed [OUT_W-1:0] cos_v;
  logic        [OUT_W-1:0] tri_t;
  logic signed [OUT_W-1:0] wave_v;

  always_comb begin
    sin_mag = {1'b0, sin_m2};
    cos_mag = {1'b0, cos_m2};
    sin_v   = sneg2 ? -sin_mag : sin_mag;
    cos_v   = cneg2 ? -cos_mag : cos_mag;
    // fold the upper half of the phase back down, then offset-binary -> two's complement
    tri_t   = u2[OUT_W] ? ~u2[OUT_W-1:0] : u2[OUT_W-1:0];
    wave_v  = sin_v;
    case (mode2)
      MODE_SINE:   wave_v = sin_v;
      MODE_SQUARE: wave_v = u2[OUT_W] ? -AMP : AMP;
      MODE_TRI:    wave_v = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
      MODE_SAW:    wave_v = {~u2[OUT_W], u2[OUT_W-1:1]};
      default:     wave_v = sin_v;
    endcase
  end

  logic signed [OUT_W-1:0] sine_r;
  logic signed [OUT_W-1:0] cos_r;
  logic signed [OUT_W-1:0] wave_r;
  logic                    vld3;
  logic                    wrap3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sine_r <= '0;
      cos_r  <= '0;
      wave_r <= '0;
      vld3   <= 1'b0;
      wrap3  <= 1'b0;
    end else begin
      sine_r <= sin_v;
      cos_r  <= cos_v;
      wave_r <= wave_v;
      vld3   <= vld2;
      wrap3  <= wrap2;
    end
  end

  assign bus.sine_out   = sine_r;
  assign bus.cosine_out = cos_r;
  assign bus.wave_out   = wave_r;
  assign bus.out_valid  = vld3;
  assign bus.wrap       = wrap3;

endmodule

// File: doc/nco_wavegen.md
# nco_wavegen

Parametrised numerically-controlled oscillator for the waveform generation path. Produces quadrature sine/cosine plus one selectable waveform (sine, square, triangle, sawtooth) from a phase accumulator, using a quarter-wave LUT and a 3-stage registered output pipeline. Adds runtime frequency loading, phase offset, phase clear, wrap indication and output-valid tracking.

## Interface
- ACC_W, 24, phase accumulator width (≥ LUT_AW+2).
- LUT_AW, 8, quarter-wave LUT address bits; full period = 2^(LUT_AW+2) points.
- OUT_W, 10, signed output width (≤ ACC_W−1).
- clock  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  accumulator advance enable.
- freq_in  input  ACC_W  frequency control word.
- freq_load  input  1  load freq_in into freq_reg.
- phase_off  input  ACC_W  phase offset added after the accumulator.
- mode  input  2  wave_out select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- sync_clr  input  1  synchronous accumulator clear.
- sine_out  output  OUT_W  signed sine.
- cosine_out  output  OUT_W  signed cosine.
- wave_out  output  OUT_W  signed selected waveform.
- out_valid  output  1  outputs correspond to an enabled accumulator step.
- wrap  output  1  one-cycle pulse aligned with the first sample after accumulator overflow.

## Operation
- Stage 0 (accumulator): sync_clr → acc=0 (priority); else en → acc=acc+freq_reg mod 2^ACC_W, carry-out captured as wrap bit; else hold. freq_load → freq_reg=freq_in, independent of sync_clr/en.
- Stage 1: p = acc + phase_off (mod 2^ACC_W); register quadrant q = p[ACC_W-1:ACC_W-2], index i = p[ACC_W-3 -: LUT_AW], mode, top OUT_W+1 phase bits, valid, wrap. Cosine uses q+1 (mod 4).
- Stage 2: quarter LUT read (registered), for sine and cosine: address = i for q∈{0,2}, ~i for q∈{1,3}. LUT[k] = round((2^(OUT_W-1)−1)·sin(π/2·(k+0.5)/2^LUT_AW)); constant, never written.
- Stage 3: negate for q∈{2,3}; range symmetric ±(2^(OUT_W-1)−1), −2^(OUT_W-1) never produced. wave_out: sine = sine_out; square = +(2^(OUT_W-1)−1) if p MSB=0 else −(2^(OUT_W-1)−1); sawtooth = {~p[MSB], next OUT_W−1 bits}; triangle = u = top OUT_W+1 bits, t = u[OUT_W] ? ~u[OUT_W-1:0] : u[OUT_W-1:0], output t − 2^(OUT_W-1).
- Pipeline advances every cycle regardless of en; with en low outputs keep reflecting held phase, out_valid low.

## Timing
- Reset: acc, freq_reg, all pipeline registers, all outputs, out_valid, wrap = 0, immediately (asynchronous); first update on first edge after release.
- Latency: acc updated at edge N → sample on outputs after edge N+3; out_valid after edge N+3 = en at edge N; wrap likewise aligned.
- freq_load at edge N: edge-N accumulate uses old freq_reg; new value first used at edge N+1.
- sync_clr at edge N: acc=0 after edge N; sample for phase 0+phase_off appears after edge N+3; sync_clr with en high gives out_valid=1 for that sample, no wrap.
- mode/phase_off sampled at stage 1 and travel with their sample; changes never tear a sample.
- freq_reg=0 with en: constant output, out_valid high, no wrap.

## Configuration
- NCO_DITHER_EN defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, steps every cycle) adds its low min(16, ACC_W−LUT_AW−2) bits to p at stage 1 only; accumulator unaffected; latency unchanged.
- Undefined: no LFSR, p exact; all tests below bit-exact with macro undefined.

## Test plan
- Defaults, reset release, freq=0, phase_off=0, mode 0, en=1 → out_valid rises exactly 3 cycles after first enabled edge; sine_out=2, cosine_out=511, wave_out=2.
- freq=2^14 (one point/cycle) → sine peaks at 511, troughs at −511, never −512; wrap pulses exactly once per 1024 valid samples.
- phase_off=2^23 vs. 0, same freq → sine_out sequences are exact negations sample-for-sample.
- mode 1, freq=2^22 → wave_out repeats +511,+511,−511,−511; mode 3, freq=2^14 → wave_out rises −512…+511 by 1 per sample.
- sync_clr and freq_load (freq_in=2^15) asserted same edge mid-run → acc=0, next step adds 2^15; output 3 cycles later equals phase-0 sample, no wrap.
- Assert reset mid-run without a clock edge → all outputs, out_valid and wrap 0 immediately; resume identical to first scenario.
